// File: rtl/servant_arb_pkg.sv
// servant_arb_pkg: shared state encoding and timeout read-data constant for the servant RAM arbiter.
package servant_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [31:0] TIMEOUT_RDT = 32'hDEADBEEF;
endpackage

// File: rtl/servant_arb_timer.sv
// servant_arb_timer: grant watchdog, flags expiry when a granted transfer waits TIMEOUT cycles for ack.
module servant_arb_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = run & ~ack & (cnt == CW'(TIMEOUT));
  // Cleared whenever no grant is active, so every grant starts from zero.
  always_ff @(posedge clk) begin
    if (rst | ~run) cnt <= '0;
    else if (~ack & ~expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/servant_wb_arbiter.sv
// servant_wb_arbiter: two-master round-robin Wishbone arbiter for the servant RAM port.
// Define SERVANT_ARB_TIMEOUT_EN to add the grant watchdog, TIMEOUT parameter and o_timeout port.
module servant_wb_arbiter
  import servant_arb_pkg::*;
#(
  parameter int AW = 32
`ifdef SERVANT_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [AW-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_cyc,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [AW-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_cyc,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [AW-1:0] o_wb_mem_adr,
  output logic [31:0]   o_wb_mem_dat,
  output logic [3:0]    o_wb_mem_sel,
  output logic          o_wb_mem_we,
  output logic          o_wb_mem_cyc,
  input  logic [31:0]   i_wb_mem_rdt,
  input  logic          i_wb_mem_ack,
  output logic          o_busy
`ifdef SERVANT_ARB_TIMEOUT_EN
  , output logic        o_timeout
`endif
);
  state_t state, state_nxt;
  logic last_gnt, last_nxt, g0, g1, own_cyc, expired;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign o_busy = g0 | g1;
  assign own_cyc = g0 ? i_wb_m0_cyc : i_wb_m1_cyc;
`ifdef SERVANT_ARB_TIMEOUT_EN
  servant_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(wb_clk),
    .rst(wb_rst),
    .run(o_busy),
    .ack(i_wb_mem_ack),
    .expired(expired)
  );
  assign o_timeout = expired;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      last_gnt <= last_nxt;
    end
  end
  // Grant ends on ack, abort or expiry; the winner is remembered so a waiting peer goes next.
  always_comb begin
    state_nxt = state;
    last_nxt = last_gnt;
    if (state == IDLE)
      state_nxt = (i_wb_m0_cyc & (~i_wb_m1_cyc | last_gnt)) ? GNT0 : i_wb_m1_cyc ? GNT1 : IDLE;
    else if (i_wb_mem_ack | ~own_cyc | expired) begin
      state_nxt = IDLE;
      last_nxt = g1;
    end
  end
  assign o_wb_mem_adr = g0 ? i_wb_m0_adr : g1 ? i_wb_m1_adr : '0;
  assign o_wb_mem_dat = g0 ? i_wb_m0_dat : g1 ? i_wb_m1_dat : '0;
  assign o_wb_mem_sel = g0 ? i_wb_m0_sel : g1 ? i_wb_m1_sel : '0;
  assign o_wb_mem_we  = g0 ? i_wb_m0_we  : g1 & i_wb_m1_we;
  assign o_wb_mem_cyc = o_busy & own_cyc & ~expired;
  assign o_wb_m0_ack = g0 & (i_wb_mem_ack | expired);
  assign o_wb_m1_ack = g1 & (i_wb_mem_ack | expired);
  assign o_wb_m0_rdt = ~g0 ? '0 : expired ? TIMEOUT_RDT : i_wb_mem_rdt;
  assign o_wb_m1_rdt = ~g1 ? '0 : expired ? TIMEOUT_RDT : i_wb_mem_rdt;
endmodule
